bin2bi_sng: RTL and testbench

BIN2BI_SNG -- requirements
Module: bin2bi_sng

---
 rtl/bin2bi_sng.sv | 81 ++++++++
 tb/tb_bin2bi_sng.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bin2bi_sng.sv
// Bipolar stochastic number generator: streams 2^WIDTH bits whose
// ones-density encodes a signed value, using a van der Corput source.
module bin2bi_sng #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] xo;
    logic [WIDTH-1:0] r;

    // Handshake flags depend on the registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == RUN);
    end

    // Random source: bit-reversed beat counter.
    always_comb begin
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = cnt[WIDTH-1-i];
        end
    end

    // Stream bit is forced low outside RUN.
    always_comb begin
        out = out_valid & (r < xo);
    end

    // Control FSM, beat counter, offset latch and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            xo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xo    <= {~in_data[WIDTH-1], in_data[WIDTH-2:0]};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bi_sng.sv
// Bench for bin2bi_sng at WIDTH=4: directed streams plus random
// values and back-pressure, checked against an arithmetic model.
module tb_bin2bi_sng;

    localparam int W   = 4;
    localparam int LEN = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic         out;
    logic         done;

    int nvec = 0;
    int nerr = 0;

    bin2bi_sng #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out       (out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected bit of beat k: reversed k, compared against the offset value.
    function automatic logic mbit(input int k, input int xo);
        int rev;
        rev = 0;
        for (int i = 0; i < W; i++) begin
            if (((k >> i) & 1) == 1) rev += 1 << (W - 1 - i);
        end
        return (rev < xo);
    endfunction

    // mode: 0 ready always, 1 stall 3 cycles at beat 5,
    //       2 random ready, 3 reset at beat 9
    task automatic stream(input logic [W-1:0] x, input int mode,
                          input bit hs, input bit hold,
                          input logic [W-1:0] nx);
        int xo;
        int k;
        int ones;
        int cyc;
        int stall;
        bit rdy;
        xo    = int'(x ^ 4'b1000);
        k     = 0;
        ones  = 0;
        cyc   = 0;
        stall = 0;
        if (hs) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_out", out, 0);
            in_valid = 1'b1;
            in_data  = x;
        end
        while (k < LEN) begin
            @(negedge clk);
            if (hold) begin
                in_valid = 1'b1;
                in_data  = x + 4'd5;
            end else begin
                in_valid = 1'b0;
            end
            chk("run_out_valid", out_valid, 1);
            chk("run_in_ready", in_ready, 0);
            chk("run_done", done, 0);
            chk($sformatf("bit x=%0d k=%0d", $signed(x), k), out,
                mbit(k, xo));
            if (mode == 3 && k == 9) begin
                out_ready = 1'b0;
                in_valid  = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_out", out, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_done", done, 0);
                @(negedge clk);
                chk("rst_hold_done", done, 0);
                @(posedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_done", done, 0);
                chk("post_rst_in_ready", in_ready, 1);
                return;
            end
            if (mode == 1 && k == 5 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 2) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            if (rdy) begin
                ones += int'(out);
                k++;
            end
            cyc++;
            if (cyc > 400) begin
                nvec++;
                nerr++;
                $error("FAIL timeout: observed %0d beats expected %0d", k, LEN);
                k = LEN;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_in_ready", in_ready, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_out", out, 0);
        chk($sformatf("ones x=%0d", $signed(x)), ones, xo);
        if (mode == 1) chk("stall_cycles", stall, 3);
        if (hold) begin
            in_valid = 1'b1;
            in_data  = nx;
        end else begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("done_cleared", done, 0);
            chk("after_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        #12;
        chk("reset_out", out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_done", done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        stream(4'sd0, 0, 1'b1, 1'b0, '0);
        stream(4'b1000, 0, 1'b1, 1'b0, '0);
        stream(4'd7, 0, 1'b1, 1'b0, '0);
        stream(4'd3, 1, 1'b1, 1'b0, '0);
        stream(4'd2, 0, 1'b1, 1'b1, 4'b1101);
        stream(4'b1101, 0, 1'b0, 1'b0, '0);
        stream(4'd6, 3, 1'b1, 1'b0, '0);
        stream(4'd1, 0, 1'b1, 1'b0, '0);

        for (int n = 0; n < 20; n++) begin
            stream(W'($urandom_range(0, LEN - 1)), 2, 1'b1, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
